// File: rtl/util_counter.sv
// util_counter: per-layer utilization statistics for the conv dataflow.
//
// Watches the monitor-side signals of the conv pipeline and accumulates cycle
// statistics for every layer: total, PE-active, lane-sum, weight and input
// stalls, and DMA-busy cycles. One registered report strobe is issued per layer.
// The block is purely observational and never back-pressures the datapath.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   dataflow_en          conv dataflow enabled
//   conv_vld[NUM_PE]     per-PE valid lanes
//   weight_req_row/frame weight loader requests (row / frame mode)
//   input_loader_req     input activation request
//   dma_start, dma_last  output DMA start and last-beat pulses
//   layer_start/done     layer boundary pulses
//   sim_done             simulation end
//   rpt_*                registered per-layer report, rpt_vld is a 1-cycle strobe
//   busy                 FSM not idle
//   sim_finished, overflow, drain_timeout, proto_err   sticky status flags
module util_counter #(
  parameter int CNT_W     = 32,
  parameter int NUM_PE    = 9,
  parameter int DRAIN_MAX = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dataflow_en,
  input  logic [NUM_PE-1:0] conv_vld,
  input  logic              weight_req_row,
  input  logic              weight_req_frame,
  input  logic              input_loader_req,
  input  logic              dma_start,
  input  logic              dma_last,
  input  logic              layer_start,
  input  logic              layer_done,
  input  logic              sim_done,
  output logic              rpt_vld,
  output logic [15:0]       rpt_layer,
  output logic [CNT_W-1:0]  rpt_total,
  output logic [CNT_W-1:0]  rpt_active,
  output logic [CNT_W+3:0]  rpt_lane_sum,
  output logic [CNT_W-1:0]  rpt_wstall,
  output logic [CNT_W-1:0]  rpt_istall,
  output logic [CNT_W-1:0]  rpt_dma,
  output logic              busy,
  output logic              sim_finished,
  output logic              overflow,
  output logic              drain_timeout,
  output logic              proto_err
);

  localparam int PC_W = $clog2(NUM_PE + 1);
  localparam int DR_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Number of asserted PE valid lanes.
  function automatic logic [PC_W-1:0] popcount(input logic [NUM_PE-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = {PC_W{1'b0}};
    for (int i = 0; i < NUM_PE; i++) begin
      cnt = cnt + {{(PC_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Saturating +en on a cycle counter; returns {blocked_increment, next_value}.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cur, input logic en);
    if (en && (&cur)) begin
      return {1'b1, cur};
    end else begin
      return {1'b0, cur + {{(CNT_W-1){1'b0}}, en}};
    end
  endfunction

  // Saturating add of a lane count; returns {saturated, next_value}.
  function automatic logic [CNT_W+4:0] sat_add_lane(input logic [CNT_W+3:0] cur,
                                                    input logic [PC_W-1:0] inc);
    logic [CNT_W+4:0] sum;
    sum = {1'b0, cur} + {{(CNT_W+5-PC_W){1'b0}}, inc};
    if (sum[CNT_W+4]) begin
      return {1'b1, {(CNT_W+4){1'b1}}};
    end else begin
      return sum;
    end
  endfunction

  state_t            state_r, state_nxt_s;
  logic              dma_act_r;
  logic [DR_W-1:0]   drain_cnt_r;
  logic [15:0]       layer_r;
  logic [CNT_W-1:0]  total_r, active_r, wstall_r, istall_r, dma_r;
  logic [CNT_W+3:0]  lane_r;

  logic              in_run_s, in_drain_s, no_vld_s;
  logic              start_ok_s, dma_act_nxt_s, drain_expire_s;
  logic              clear_s, report_s, busy_nxt_s, proto_set_s, ovf_hit_s;
  logic [PC_W-1:0]   lanes_s;
  logic [CNT_W:0]    total_inc_s, active_inc_s, wstall_inc_s, istall_inc_s, dma_inc_s;
  logic [CNT_W+4:0]  lane_inc_s;
  logic [CNT_W-1:0]  total_nxt_s, active_nxt_s, wstall_nxt_s, istall_nxt_s, dma_nxt_s;
  logic [CNT_W+3:0]  lane_nxt_s;

  assign in_run_s      = (state_r == ST_RUN);
  assign in_drain_s    = (state_r == ST_DRAIN);
  assign no_vld_s      = ~(|conv_vld);
  // Once the simulation is over, new layers are no longer accepted.
  assign start_ok_s    = layer_start & ~sim_finished & ~sim_done;
  // DMA outstanding after this cycle (start+last together leaves it clear).
  assign dma_act_nxt_s = (dma_act_r | dma_start) & ~dma_last;
  assign drain_expire_s = in_drain_s && (drain_cnt_r == DR_W'(DRAIN_MAX - 1)) && !dma_last;
  assign lanes_s       = popcount(conv_vld);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (sim_done)        state_nxt_s = ST_REPORT;
        else if (layer_done) state_nxt_s = dma_act_nxt_s ? ST_DRAIN : ST_REPORT;
        else                 state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (sim_done || dma_last || drain_expire_s) state_nxt_s = ST_REPORT;
        else                                        state_nxt_s = ST_DRAIN;
      end
      ST_REPORT: begin
        if (start_ok_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: counter clear, report snapshot, busy and protocol errors.
  always_comb begin
    clear_s     = 1'b0;
    report_s    = 1'b0;
    proto_set_s = 1'b0;
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        clear_s     = start_ok_s;
        proto_set_s = layer_done;
      end
      ST_RUN: begin
        report_s    = (state_nxt_s == ST_REPORT);
        proto_set_s = layer_start | (dma_last & ~dma_act_r & ~dma_start);
      end
      ST_DRAIN: begin
        report_s    = (state_nxt_s == ST_REPORT);
        proto_set_s = dma_last & ~dma_act_r & ~dma_start;
      end
      ST_REPORT: begin
        clear_s = start_ok_s;
      end
      default: begin
        clear_s = 1'b0;
      end
    endcase
  end

  // Per-cycle increments; DRAIN keeps only total and dma running.
  assign total_inc_s  = sat_inc(total_r,  in_run_s | in_drain_s);
  assign active_inc_s = sat_inc(active_r, in_run_s & dataflow_en & ~no_vld_s);
  assign lane_inc_s   = sat_add_lane(lane_r, (in_run_s & dataflow_en) ? lanes_s : {PC_W{1'b0}});
  assign wstall_inc_s = sat_inc(wstall_r, in_run_s & (weight_req_row | weight_req_frame) & no_vld_s);
  assign istall_inc_s = sat_inc(istall_r, in_run_s & input_loader_req & no_vld_s);
  assign dma_inc_s    = sat_inc(dma_r, (in_run_s | in_drain_s) & (dma_act_r | dma_start));
  assign ovf_hit_s    = total_inc_s[CNT_W] | active_inc_s[CNT_W] | lane_inc_s[CNT_W+4] |
                        wstall_inc_s[CNT_W] | istall_inc_s[CNT_W] | dma_inc_s[CNT_W];

  assign total_nxt_s  = clear_s ? {CNT_W{1'b0}}     : total_inc_s[CNT_W-1:0];
  assign active_nxt_s = clear_s ? {CNT_W{1'b0}}     : active_inc_s[CNT_W-1:0];
  assign lane_nxt_s   = clear_s ? {(CNT_W+4){1'b0}} : lane_inc_s[CNT_W+3:0];
  assign wstall_nxt_s = clear_s ? {CNT_W{1'b0}}     : wstall_inc_s[CNT_W-1:0];
  assign istall_nxt_s = clear_s ? {CNT_W{1'b0}}     : istall_inc_s[CNT_W-1:0];
  assign dma_nxt_s    = clear_s ? {CNT_W{1'b0}}     : dma_inc_s[CNT_W-1:0];

  // Live statistic counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total_r  <= {CNT_W{1'b0}};
      active_r <= {CNT_W{1'b0}};
      lane_r   <= {(CNT_W+4){1'b0}};
      wstall_r <= {CNT_W{1'b0}};
      istall_r <= {CNT_W{1'b0}};
      dma_r    <= {CNT_W{1'b0}};
    end else begin
      total_r  <= total_nxt_s;
      active_r <= active_nxt_s;
      lane_r   <= lane_nxt_s;
      wstall_r <= wstall_nxt_s;
      istall_r <= istall_nxt_s;
      dma_r    <= dma_nxt_s;
    end
  end

  // Report snapshot; takes the counters' final values so rpt_vld appears in the REPORT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rpt_vld      <= 1'b0;
      rpt_layer    <= 16'd0;
      rpt_total    <= {CNT_W{1'b0}};
      rpt_active   <= {CNT_W{1'b0}};
      rpt_lane_sum <= {(CNT_W+4){1'b0}};
      rpt_wstall   <= {CNT_W{1'b0}};
      rpt_istall   <= {CNT_W{1'b0}};
      rpt_dma      <= {CNT_W{1'b0}};
      layer_r      <= 16'd0;
    end else begin
      rpt_vld <= report_s;
      if (report_s) begin
        rpt_layer    <= layer_r;
        rpt_total    <= total_nxt_s;
        rpt_active   <= active_nxt_s;
        rpt_lane_sum <= lane_nxt_s;
        rpt_wstall   <= wstall_nxt_s;
        rpt_istall   <= istall_nxt_s;
        rpt_dma      <= dma_nxt_s;
        layer_r      <= layer_r + 16'd1;  // wraps 0xFFFF -> 0
      end
    end
  end

  // DMA tracking, drain timer, busy and sticky status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_act_r     <= 1'b0;
      drain_cnt_r   <= {DR_W{1'b0}};
      busy          <= 1'b0;
      sim_finished  <= 1'b0;
      overflow      <= 1'b0;
      drain_timeout <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      if (clear_s) begin
        dma_act_r <= 1'b0;
      end else if (in_run_s || in_drain_s) begin
        dma_act_r <= dma_act_nxt_s;
      end
      drain_cnt_r   <= in_drain_s ? drain_cnt_r + {{(DR_W-1){1'b0}}, 1'b1} : {DR_W{1'b0}};
      busy          <= busy_nxt_s;
      sim_finished  <= sim_finished | sim_done;
      overflow      <= overflow | ovf_hit_s;
      drain_timeout <= drain_timeout | drain_expire_s;
      proto_err     <= proto_err | proto_set_s;
    end
  end

endmodule

// File: tb/tb_util_counter.sv
// Directed self-checking bench for util_counter (DRAIN_MAX reduced to 4).
// Inputs change 1 ns after each rising edge; "cycle N" is the interval in
// which the inputs for the N-th sampling edge after layer_start are driven.
module tb_util_counter;

  localparam int CNT_W  = 32;
  localparam int NUM_PE = 9;

  logic              clk = 1'b0;
  logic              rstn;
  logic              dataflow_en, weight_req_row, weight_req_frame, input_loader_req;
  logic [NUM_PE-1:0] conv_vld;
  logic              dma_start, dma_last, layer_start, layer_done, sim_done;
  logic              rpt_vld, busy, sim_finished, overflow, drain_timeout, proto_err;
  logic [15:0]       rpt_layer;
  logic [CNT_W-1:0]  rpt_total, rpt_active, rpt_wstall, rpt_istall, rpt_dma;
  logic [CNT_W+3:0]  rpt_lane_sum;

  int n_cmp = 0;
  int n_err = 0;

  util_counter #(.CNT_W(CNT_W), .NUM_PE(NUM_PE), .DRAIN_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
    .weight_req_row(weight_req_row), .weight_req_frame(weight_req_frame),
    .input_loader_req(input_loader_req), .dma_start(dma_start), .dma_last(dma_last),
    .layer_start(layer_start), .layer_done(layer_done), .sim_done(sim_done),
    .rpt_vld(rpt_vld), .rpt_layer(rpt_layer), .rpt_total(rpt_total),
    .rpt_active(rpt_active), .rpt_lane_sum(rpt_lane_sum), .rpt_wstall(rpt_wstall),
    .rpt_istall(rpt_istall), .rpt_dma(rpt_dma), .busy(busy),
    .sim_finished(sim_finished), .overflow(overflow), .drain_timeout(drain_timeout),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    dataflow_en = 1'b0; conv_vld = 9'h000; weight_req_row = 1'b0; weight_req_frame = 1'b0;
    input_loader_req = 1'b0; dma_start = 1'b0; dma_last = 1'b0;
    layer_start = 1'b0; layer_done = 1'b0; sim_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    clr_in();
    rstn = 1'b0;
    tick(); tick();
    // Reset state
    check_val("rst_vld", rpt_vld, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_total", rpt_total, 32'd0);
    check_val("rst_flags", {sim_finished, overflow, drain_timeout, proto_err}, 4'b0000);
    rstn = 1'b1;
    tick();

    // Basic layer: full lanes for 10 cycles
    layer_start = 1'b1; tick(); clr_in();
    check_val("basic_busy", busy, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      dataflow_en = 1'b1; conv_vld = 9'h1FF; layer_done = (c == 10);
      if (c == 10) check_val("basic_early_vld", rpt_vld, 1'b0);
      tick();
    end
    clr_in();
    check_val("basic_vld", rpt_vld, 1'b1);
    check_val("basic_total", rpt_total, 32'd10);
    check_val("basic_active", rpt_active, 32'd10);
    check_val("basic_lane", rpt_lane_sum, 36'd90);
    check_val("basic_layer", rpt_layer, 16'd0);
    check_val("basic_stalls", {rpt_wstall, rpt_istall, rpt_dma}, 96'd0);
    tick();
    check_val("basic_vld_drop", rpt_vld, 1'b0);
    check_val("basic_idle", busy, 1'b0);
    check_val("basic_hold", rpt_total, 32'd10);

    // Stalls plus partial lanes and a dataflow_en=0 cycle
    layer_start = 1'b1; tick(); clr_in();
    for (int c = 1; c <= 11; c++) begin
      clr_in();
      if (c <= 5) begin dataflow_en = 1'b1; weight_req_row = 1'b1; end
      else if (c <= 8) begin dataflow_en = 1'b1; input_loader_req = 1'b1; end
      else if (c <= 10) begin dataflow_en = 1'b1; conv_vld = 9'h005; end
      else begin conv_vld = 9'h1FF; weight_req_frame = 1'b1; layer_done = 1'b1; end
      tick();
    end
    clr_in();
    check_val("stall_vld", rpt_vld, 1'b1);
    check_val("stall_total", rpt_total, 32'd11);
    check_val("stall_wstall", rpt_wstall, 32'd5);
    check_val("stall_istall", rpt_istall, 32'd3);
    check_val("stall_active", rpt_active, 32'd2);
    check_val("stall_lane", rpt_lane_sum, 36'd4);
    check_val("stall_layer", rpt_layer, 16'd1);
    tick();

    // DMA drain: start@8, done@10, last@14
    layer_start = 1'b1; tick(); clr_in();
    for (int c = 1; c <= 14; c++) begin
      dma_start = (c == 8); layer_done = (c == 10); dma_last = (c == 14);
      if (c == 11 || c == 14) check_val("drain_no_vld", rpt_vld, 1'b0);
      if (c == 12) check_val("drain_busy", busy, 1'b1);
      tick();
    end
    clr_in();
    check_val("drain_vld", rpt_vld, 1'b1);
    check_val("drain_total", rpt_total, 32'd14);
    check_val("drain_dma", rpt_dma, 32'd7);
    check_val("drain_layer", rpt_layer, 16'd2);
    check_val("drain_flags", {drain_timeout, proto_err}, 2'b00);
    tick();

    // Back-to-back layers
    layer_start = 1'b1; tick(); clr_in();
    for (int c = 1; c <= 3; c++) begin
      dataflow_en = 1'b1; conv_vld = 9'h003; layer_done = (c == 3);
      tick();
    end
    clr_in();
    layer_start = 1'b1;
    check_val("b2b_vld1", rpt_vld, 1'b1);
    check_val("b2b_layer1", rpt_layer, 16'd3);
    check_val("b2b_total1", rpt_total, 32'd3);
    check_val("b2b_lane1", rpt_lane_sum, 36'd6);
    tick(); clr_in();
    for (int c = 5; c <= 6; c++) begin
      dataflow_en = 1'b1; conv_vld = 9'h1FF; layer_done = (c == 6);
      check_val("b2b_hold_total", rpt_total, 32'd3);
      check_val("b2b_hold_vld", rpt_vld, 1'b0);
      tick();
    end
    clr_in();
    check_val("b2b_vld2", rpt_vld, 1'b1);
    check_val("b2b_layer2", rpt_layer, 16'd4);
    check_val("b2b_total2", rpt_total, 32'd2);
    check_val("b2b_lane2", rpt_lane_sum, 36'd18);
    tick();

    // dma_start and dma_last together: one DMA cycle, no drain, no error
    layer_start = 1'b1; tick(); clr_in();
    dma_start = 1'b1; dma_last = 1'b1; tick(); clr_in();
    layer_done = 1'b1; tick(); clr_in();
    check_val("same_vld", rpt_vld, 1'b1);
    check_val("same_dma", rpt_dma, 32'd1);
    check_val("same_total", rpt_total, 32'd2);
    check_val("same_proto", proto_err, 1'b0);
    tick();

    // dma_last without dma_start, then a DMA that never ends -> drain timeout
    layer_start = 1'b1; tick(); clr_in();
    dma_last = 1'b1; tick(); clr_in();
    check_val("err_last_proto", proto_err, 1'b1);
    dma_start = 1'b1; tick(); clr_in();
    layer_done = 1'b1; tick(); clr_in();
    for (int c = 4; c <= 7; c++) begin
      check_val("tmo_no_vld", rpt_vld, 1'b0);
      if (c == 7) check_val("tmo_not_yet", drain_timeout, 1'b0);
      tick();
    end
    check_val("tmo_vld", rpt_vld, 1'b1);
    check_val("tmo_flag", drain_timeout, 1'b1);
    check_val("tmo_total", rpt_total, 32'd7);
    check_val("tmo_dma", rpt_dma, 32'd6);
    check_val("tmo_layer", rpt_layer, 16'd6);
    check_val("ovf_clear", overflow, 1'b0);
    tick();

    // Reset clears everything; layer_start in RUN is a protocol error
    rstn = 1'b0; tick();
    check_val("rst2_out", {rpt_total, rpt_dma, rpt_layer}, 80'd0);
    check_val("rst2_flags", {busy, rpt_vld, drain_timeout, proto_err}, 4'b0000);
    rstn = 1'b1; tick();
    layer_start = 1'b1; tick(); clr_in();
    layer_start = 1'b1; tick(); clr_in();
    check_val("err_start_proto", proto_err, 1'b1);
    dataflow_en = 1'b1; conv_vld = 9'h1FF; tick();
    // Reset mid-RUN, with layer_done arriving while in reset
    rstn = 1'b0; #1;
    check_val("midrst_flags", {busy, rpt_vld, proto_err}, 3'b000);
    check_val("midrst_rpt", {rpt_total, rpt_active, rpt_lane_sum, rpt_layer}, 116'd0);
    layer_done = 1'b1; tick(); clr_in();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("midrst_no_rpt", rpt_vld, 1'b0);
    end
    // layer_done while idle
    layer_done = 1'b1; tick(); clr_in();
    check_val("idle_done_proto", proto_err, 1'b1);
    check_val("idle_done_busy", busy, 1'b0);

    // sim_done in RUN forces a report and blocks later layers
    do_reset();
    layer_start = 1'b1; tick(); clr_in();
    for (int c = 1; c <= 3; c++) begin
      dataflow_en = 1'b1; conv_vld = 9'h1FF; sim_done = (c == 3);
      if (c == 3) check_val("sim_not_yet", sim_finished, 1'b0);
      tick();
    end
    clr_in();
    check_val("sim_vld", rpt_vld, 1'b1);
    check_val("sim_total", rpt_total, 32'd3);
    check_val("sim_lane", rpt_lane_sum, 36'd27);
    check_val("sim_layer", rpt_layer, 16'd0);
    check_val("sim_fin", sim_finished, 1'b1);
    tick();
    layer_start = 1'b1; tick(); clr_in();
    check_val("sim_ignore_busy", busy, 1'b0);
    tick();
    check_val("sim_ignore_busy2", busy, 1'b0);
    check_val("sim_fin_sticky", sim_finished, 1'b1);
    check_val("sim_no_rpt", rpt_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
